// File: rtl/sample_window_buf.sv
// Circular sample buffer feeding a windowed fit stage. It launches a fit whenever WIN samples are
// resident, captures the result and slides the window forward by HOP samples.
module sample_window_buf #(
  parameter int DEPTH = 16,
  parameter int WIN   = 10,
  parameter int HOP   = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        fit_start,
  output logic [31:0] fit_si,
  output logic [31:0] fit_ei,
  input  logic [31:0] fit_index,
  output logic [31:0] fit_value,
  input  logic        fit_done,
  input  logic [31:0] fit_mean,
  input  logic [31:0] fit_dev,
  output logic        out_valid,
  output logic [31:0] out_mean,
  output logic [31:0] out_dev,
  output logic [31:0] out_base
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   WIN_C   = (AW+1)'(WIN);
  localparam logic [AW:0]   HOP_C   = (AW+1)'(HOP);
  localparam logic [AW-1:0] HOP_A   = AW'(HOP);
  localparam logic [31:0]   WIN_32  = 32'(WIN);
  localparam logic [31:0]   HOP_32  = 32'(HOP);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t        state_reg;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] base_reg;
  logic [AW:0]   occ_reg;
  logic [31:0]   abs_base_reg;
  logic          fit_start_reg;
  logic          out_valid_reg;
  logic [31:0]   out_mean_reg;
  logic [31:0]   out_dev_reg;
  logic [31:0]   out_base_reg;
  logic          wr_en;
  logic          done_evt;
  logic [AW-1:0] rd_addr;

  assign in_ready = (occ_reg < DEPTH_C) & ~Rst;
  assign wr_en    = in_valid & in_ready;
  assign done_evt = (state_reg == BUSY) & fit_done;

  // Reads are window-relative; base only moves on completion, so the window is stable while fitting.
  assign rd_addr   = base_reg + fit_index[AW-1:0];
  assign fit_value = (fit_index < WIN_32) ? mem[rd_addr] : 32'd0;

  assign fit_si    = 32'd0;
  assign fit_ei    = WIN_32;
  assign fit_start = fit_start_reg;
  assign out_valid = out_valid_reg;
  assign out_mean  = out_mean_reg;
  assign out_dev   = out_dev_reg;
  assign out_base  = out_base_reg;

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      base_reg      <= '0;
      occ_reg       <= '0;
      abs_base_reg  <= '0;
      fit_start_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_mean_reg  <= '0;
      out_dev_reg   <= '0;
      out_base_reg  <= '0;
    end else begin
      fit_start_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      // A write and a completion in the same cycle net out to +1-HOP.
      occ_reg <= occ_reg + {{AW{1'b0}}, wr_en} - (done_evt ? HOP_C : '0);
      case (state_reg)
        IDLE: begin
          if (occ_reg >= WIN_C) begin
            state_reg     <= START;
            fit_start_reg <= 1'b1;
          end
        end
        START: state_reg <= BUSY;
        BUSY: begin
          if (fit_done) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b1;
            out_mean_reg  <= fit_mean;
            out_dev_reg   <= fit_dev;
            out_base_reg  <= abs_base_reg;
            base_reg      <= base_reg + HOP_A;
            abs_base_reg  <= abs_base_reg + HOP_32;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_window_buf.sv
// Bench for sample_window_buf: directed scenarios plus randomized traffic, checked against a
// reference model that tracks absolute sample numbers instead of circular pointers.
module tb_sample_window_buf;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        fit_start;
  logic [31:0] fit_si;
  logic [31:0] fit_ei;
  logic [31:0] fit_index;
  logic [31:0] fit_value;
  logic        fit_done;
  logic [31:0] fit_mean;
  logic [31:0] fit_dev;
  logic        out_valid;
  logic [31:0] out_mean;
  logic [31:0] out_dev;
  logic [31:0] out_base;

  always #5 Clk = ~Clk;

  sample_window_buf dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fit_start(fit_start), .fit_si(fit_si), .fit_ei(fit_ei), .fit_index(fit_index),
    .fit_value(fit_value), .fit_done(fit_done), .fit_mean(fit_mean), .fit_dev(fit_dev),
    .out_valid(out_valid), .out_mean(out_mean), .out_dev(out_dev), .out_base(out_base)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted sample gets an absolute number; the window starts at win_abs.
  logic [31:0] hist [int];
  int          n_acc, win_abs, phase;   // phase: 0 waiting, 1 launch cycle, 2 fit in progress
  int          n_fits, n_start;
  bit          last_acc;
  logic        m_ov;
  logic [31:0] m_mean, m_dev, m_base;

  function automatic int occ();
    return n_acc - win_abs;
  endfunction

  function automatic void model_reset();
    n_acc = 0; win_abs = 0; phase = 0; last_acc = 0;
    m_ov = 1'b0; m_mean = '0; m_dev = '0; m_base = '0;
  endfunction

  // One clock cycle: inputs already driven; compare at negedge, then advance the model at posedge.
  task automatic cycle();
    int  o, idx;
    bit  acc, done;
    @(negedge Clk);
    check("in_ready", 32'(in_ready), 32'((!Rst && occ() < 16) ? 1 : 0));
    check("fit_start", 32'(fit_start), 32'((phase == 1) ? 1 : 0));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_mean", out_mean, m_mean);
    check("out_dev", out_dev, m_dev);
    check("out_base", out_base, m_base);
    if (fit_index >= 32'd10) check("fit_value_oob", fit_value, 32'd0);
    else begin
      idx = int'(fit_index);
      if (win_abs + idx < n_acc) check("fit_value", fit_value, hist[win_abs + idx]);
    end
    if (fit_start === 1'b1) n_start++;
    @(posedge Clk);
    if (Rst) model_reset();
    else begin
      o    = occ();
      acc  = in_valid && (o < 16);
      done = (phase == 2) && fit_done;
      last_acc = acc;
      m_ov = done;
      if (done) begin
        m_mean = fit_mean; m_dev = fit_dev; m_base = 32'(win_abs);
        $display("fit %0d: base=%0d mean=0x%08h dev=0x%08h", n_fits, win_abs, fit_mean, fit_dev);
        n_fits++;
        win_abs += 5;
      end
      if (acc) begin
        hist[n_acc] = in_data;
        n_acc++;
      end
      case (phase)
        0: if (o >= 10) phase = 1;
        1: phase = 2;
        default: if (done) phase = 0;
      endcase
    end
    #1;
  endtask

  logic [31:0] vals [10];
  logic [31:0] next_data;

  initial begin
    vals = '{32'd33, 32'd23, 32'd15, 32'd12, 32'd82, 32'd64, 32'd53, 32'd58, 32'd66, 32'd39};
    n_fits = 0; n_start = 0;
    Rst = 1'b1; in_valid = 1'b0; in_data = '0; fit_index = '0;
    fit_done = 1'b0; fit_mean = '0; fit_dev = '0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    cycle();                      // reset still high: in_ready must be low, outputs zero
    Rst = 1'b0;
    check("fit_si", fit_si, 32'd0);
    check("fit_ei", fit_ei, 32'd10);

    // Single fit with the fixed sample set.
    n_start = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      fit_index = 32'(i);
      #1;
      check("single_rd", fit_value, (i < 10) ? vals[i] : 32'd0);
      cycle();
    end
    check("single_starts", 32'(n_start), 32'd1);
    fit_done = 1'b1; fit_mean = 32'd44; fit_dev = 32'd7;
    cycle();
    fit_done = 1'b0;
    check("single_ov", 32'(out_valid), 32'd1);
    check("single_mean", out_mean, 32'd44);
    check("single_dev", out_dev, 32'd7);
    check("single_base", out_base, 32'd0);
    cycle();

    // Backpressure: fill the buffer while the fit never completes.
    Rst = 1'b1; cycle(); Rst = 1'b0;
    next_data = $urandom;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = next_data;
      fit_index = 32'($urandom_range(0, 9));
      cycle();
      if (last_acc) next_data = $urandom;
    end
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_accepted", 32'(n_acc), 32'd16);
    fit_done = 1'b1; fit_mean = $urandom; fit_dev = $urandom;
    cycle();
    fit_done = 1'b0;
    check("bp_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b0;
      fit_index = 32'(i % 10);
      cycle();
    end

    // Reset while a fit is in progress, then a stray done.
    for (int k = 0; k < 20 && phase != 2; k++) cycle();
    check("reach_busy", 32'(phase), 32'd2);
    Rst = 1'b1; cycle(); Rst = 1'b0;
    fit_done = 1'b1;
    cycle();
    check("rst_no_ov", 32'(out_valid), 32'd0);
    check("rst_base", out_base, 32'd0);
    cycle();
    fit_done = 1'b0;

    // Randomized traffic: bursts alternate between slow and fast producers.
    for (int c = 0; c < 6000; c++) begin
      in_valid  = ($urandom_range(0, 9) < (((c / 400) % 2 == 1) ? 9 : 4));
      in_data   = $urandom;
      fit_index = 32'($urandom_range(0, 11));
      fit_done  = ((phase == 2) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 7) == 0);
      fit_mean  = $urandom;
      fit_dev   = $urandom;
      Rst       = ($urandom_range(0, 699) == 0);
      cycle();
    end
    Rst = 1'b0; in_valid = 1'b0; fit_done = 1'b0;
    check("fits_seen", 32'((n_fits > 20) ? 1 : 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
